// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared types and constants for the song sequencer
//
// Purpose : FSM state encoding, song ROM entry layout, entry code values and
//           the 62-note tuning table (phase_inc words for a 25 MHz clock).
// Ports   : none (package).
package song_pkg;

  localparam int PHASE_W   = 24;
  localparam int ROM_DEPTH = 64;

  localparam logic [5:0] CODE_REST = 6'd0;
  localparam logic [5:0] CODE_END  = 6'd63;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [5:0] code;
    logic [9:0] dur_ms;
  } rom_entry_t;

  // Code k is MIDI note 35+k: code 1 = C2 ... code 34 = A4 ... code 62 = C#7.
  // Word = round(f_note * 2^24 / 25e6).
  localparam logic [PHASE_W-1:0] TUNING_TABLE [0:61] = '{
    24'd44,   24'd47,   24'd49,   24'd52,   24'd55,   24'd59,
    24'd62,   24'd66,   24'd70,   24'd74,   24'd78,   24'd83,
    24'd88,   24'd93,   24'd99,   24'd104,  24'd111,  24'd117,
    24'd124,  24'd132,  24'd139,  24'd148,  24'd156,  24'd166,
    24'd176,  24'd186,  24'd197,  24'd209,  24'd221,  24'd234,
    24'd248,  24'd263,  24'd279,  24'd295,  24'd313,  24'd331,
    24'd351,  24'd372,  24'd394,  24'd418,  24'd442,  24'd469,
    24'd497,  24'd526,  24'd557,  24'd591,  24'd626,  24'd663,
    24'd702,  24'd744,  24'd788,  24'd835,  24'd885,  24'd937,
    24'd993,  24'd1052, 24'd1115, 24'd1181, 24'd1251, 24'd1326,
    24'd1405, 24'd1488
  };

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - 4 x 64 song ROM with a registered read port
//
// Purpose : holds the song contents; one cycle from address to entry.
// Ports   : clk_i   - clock
//           song_i  - song number (upper address bits)
//           addr_i  - entry address within the song
//           entry_o - {code, dur_ms} registered from the previous cycle's address
module song_rom
  import song_pkg::*;
(
  input  logic       clk_i,
  input  logic [1:0] song_i,
  input  logic [5:0] addr_i,
  output rom_entry_t entry_o
);

  localparam logic [5:0] NOTE_A4 = 6'd34;
  localparam logic [5:0] NOTE_C5 = 6'd37;

  function automatic rom_entry_t mk(input logic [5:0] code, input logic [9:0] dur);
    rom_entry_t e;
    e.code   = code;
    e.dur_ms = dur;
    return e;
  endfunction

  // Unlisted entries read as END so short songs terminate cleanly.
  function automatic rom_entry_t lookup(input logic [1:0] song, input logic [5:0] addr);
    rom_entry_t e;
    e = mk(CODE_END, 10'd0);
    case (song)
      2'd0: if (addr == 6'd0) e = mk(NOTE_A4, 10'd3);
      2'd1: begin
        if (addr == 6'd0) e = mk(CODE_REST, 10'd2);
        if (addr == 6'd1) e = mk(NOTE_C5, 10'd1);
      end
      2'd2: begin
        if (addr == 6'd0) e = mk(NOTE_C5, 10'd0);
        if (addr == 6'd1) e = mk(NOTE_A4, 10'd1);
      end
      // Song 3 has no END marker: 64 alternating A4/C5 entries.
      default: e = addr[0] ? mk(NOTE_C5, 10'd1) : mk(NOTE_A4, 10'd1);
    endcase
    return e;
  endfunction

  rom_entry_t entry_q;

  always_ff @(posedge clk_i) begin
    entry_q <= lookup(song_i, addr_i);
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - ROM-driven song player producing sine tuning words
//
// Purpose : steps through a song in the song ROM, holding each note's tuning
//           word for dur_ms ticks followed by GAP_MS silent ticks.
// Ports   : clock25     - sole clock, rising edge
//           reset       - asynchronous active-high reset
//           enable      - 1 = play, 0 = stop and silence
//           song_select - song number, latched when a song starts
//           loop        - 1 = restart at entry 0 on end of song
//           phase_inc   - tuning word for the sine generator, 0 = silence
//           note_on     - 1 while a pitched note sounds
//           note_index  - ROM address of the current entry
//           song_done   - one-cycle pulse at the end of a non-looping song
module song_sequencer
  import song_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000,
  parameter int GAP_MS  = 20
) (
  input  logic               clock25,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         song_select,
  input  logic               loop,
  output logic [PHASE_W-1:0] phase_inc,
  output logic               note_on,
  output logic [5:0]         note_index,
  output logic               song_done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W    = (GAP_MS > 1) ? $clog2(GAP_MS + 1) : 1;
  localparam logic [5:0] LAST_ADDR = 6'(ROM_DEPTH - 1);

  state_t               state_q;
  logic [5:0]           addr_q;
  logic [1:0]           song_q;
  logic [9:0]           dur_q;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   presc_d;
  logic [GAP_W-1:0]     gap_q;
  logic [PHASE_W-1:0]   phase_inc_q;
  logic                 note_on_q;
  logic [5:0]           note_index_q;
  logic                 song_done_q;

  rom_entry_t rom_entry;
  logic       tick;
  logic       play_last;
  logic       gap_last;
  logic       advance;
  logic       end_hit;
  logic       step_next;

  function automatic logic [PHASE_W-1:0] tune(input logic [5:0] code);
    if (code == CODE_REST || code == CODE_END) return '0;
    return TUNING_TABLE[code - 6'd1];
  endfunction

  song_rom u_rom (
    .clk_i   (clock25),
    .song_i  (song_q),
    .addr_i  (addr_q),
    .entry_o (rom_entry)
  );

  always_comb begin
    tick      = (presc_q == PRESC_W'(TICK_DIV - 1));
    presc_d   = tick ? '0 : presc_q + 1'b1;
    play_last = (state_q == S_PLAY) && tick && (dur_q == 10'd1);
    gap_last  = (state_q == S_GAP) && tick && (gap_q == GAP_W'(1));
    advance   = (play_last && (GAP_MS == 0)) || gap_last;
    // Running off the last entry behaves exactly like reading END.
    end_hit   = ((state_q == S_LOAD) && (rom_entry.code == CODE_END)) ||
                (advance && (addr_q == LAST_ADDR));
    step_next = advance && (addr_q != LAST_ADDR);
  end

  // Later assignments in this block override earlier ones: the state case
  // first, then advance/END handling, then enable=0 which beats everything.
  always_ff @(posedge clock25 or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      song_q       <= '0;
      dur_q        <= '0;
      presc_q      <= '0;
      gap_q        <= '0;
      phase_inc_q  <= '0;
      note_on_q    <= 1'b0;
      note_index_q <= '0;
      song_done_q  <= 1'b0;
    end else begin
      song_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            song_q  <= song_select;
            addr_q  <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          if (rom_entry.code != CODE_END) begin
            dur_q        <= (rom_entry.dur_ms == 10'd0) ? 10'd1 : rom_entry.dur_ms;
            presc_q      <= '0;
            phase_inc_q  <= tune(rom_entry.code);
            note_on_q    <= (rom_entry.code != CODE_REST);
            note_index_q <= addr_q;
            state_q      <= S_PLAY;
          end
        end
        S_PLAY: begin
          presc_q <= presc_d;
          if (tick) begin
            dur_q <= dur_q - 1'b1;
            if (dur_q == 10'd1) begin
              phase_inc_q <= '0;
              note_on_q   <= 1'b0;
              gap_q       <= GAP_W'(GAP_MS);
              state_q     <= S_GAP;
            end
          end
        end
        S_GAP: begin
          presc_q <= presc_d;
          if (tick) gap_q <= gap_q - 1'b1;
        end
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase

      if (step_next) begin
        addr_q  <= addr_q + 1'b1;
        state_q <= S_FETCH;
      end

      if (end_hit) begin
        if (loop) begin
          addr_q  <= '0;
          state_q <= S_FETCH;
        end else begin
          song_done_q  <= 1'b1;
          phase_inc_q  <= '0;
          note_on_q    <= 1'b0;
          note_index_q <= '0;
          state_q      <= S_DONE;
        end
      end

      if (!enable) begin
        state_q      <= S_IDLE;
        addr_q       <= '0;
        presc_q      <= '0;
        phase_inc_q  <= '0;
        note_on_q    <= 1'b0;
        note_index_q <= '0;
        song_done_q  <= 1'b0;
      end
    end
  end

  assign phase_inc  = phase_inc_q;
  assign note_on    = note_on_q;
  assign note_index = note_index_q;
  assign song_done  = song_done_q;

endmodule
